// File: rtl/idma_txrx_tx_endpoint_pkg.sv
// Shared types for the iDMA TXRX write-port endpoint: TXRX channel structs,
// FSM state encoding and the word FIFO entry format.
package idma_txrx_tx_endpoint_pkg;

    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned TF_LEN_WIDTH   = 32;
    localparam int unsigned BYTES_PER_WORD = DATA_WIDTH / 8;
    localparam int unsigned BYTE_CNT_WIDTH = $clog2(BYTES_PER_WORD + 1);

    typedef logic [TF_LEN_WIDTH-1:0]   tf_len_t;
    typedef logic [BYTE_CNT_WIDTH-1:0] byte_cnt_t;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN
    } endpoint_state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
    } txrx_a_chan_t;

    typedef struct packed {
        txrx_a_chan_t a;
        logic         valid;
    } txrx_req_t;

    typedef struct packed {
        tf_len_t datasize;
        tf_len_t bytes_left;
    } txrx_r_chan_t;

    typedef struct packed {
        txrx_r_chan_t r;
        logic         req;
        logic         ready;
    } txrx_rsp_t;

    // last marks the final word of a transfer; cnt is its number of valid bytes
    typedef struct packed {
        logic                  last;
        byte_cnt_t             cnt;
        logic [DATA_WIDTH-1:0] data;
    } word_entry_t;

    function automatic byte_cnt_t push_bytes(input tf_len_t bytes_left);
        if (bytes_left >= tf_len_t'(BYTES_PER_WORD)) begin
            return byte_cnt_t'(BYTES_PER_WORD);
        end
        return byte_cnt_t'(bytes_left);
    endfunction

endpackage

// File: rtl/idma_txrx_tx_endpoint_serializer.sv
// Word-to-byte shift register: emits the low byte first and reloads from the
// FIFO in the same cycle its last valid byte is taken, so words flow without bubbles.
module idma_txrx_tx_endpoint_serializer
    import idma_txrx_tx_endpoint_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        word_valid_i,
    input  word_entry_t word_i,
    output logic        word_pop_o,
    output logic [7:0]  tx_byte_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        tx_last_o
);

    logic [DATA_WIDTH-1:0] r_shift;
    byte_cnt_t             r_cnt;
    logic                  r_last;

    logic w_hs;
    logic w_load;

    assign w_hs   = (r_cnt != '0) && tx_ready_i;
    assign w_load = word_valid_i && ((r_cnt == '0) || (w_hs && (r_cnt == byte_cnt_t'(1))));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_last  <= 1'b0;
        end else if (w_load) begin
            r_shift <= word_i.data;
            r_cnt   <= word_i.cnt;
            r_last  <= word_i.last;
        end else if (w_hs) begin
            r_shift <= r_shift >> 8;
            r_cnt   <= r_cnt - byte_cnt_t'(1);
        end
    end

    assign word_pop_o = w_load;
    assign tx_valid_o = (r_cnt != '0);
    assign tx_byte_o  = r_shift[7:0];
    assign tx_last_o  = r_last && (r_cnt == byte_cnt_t'(1));

endmodule

// File: rtl/idma_txrx_tx_endpoint.sv
// Peripheral-side TXRX write-port responder: accepts iDMA data words into a
// small FIFO and hands them to a byte serializer feeding a byte-wide link.
//
// state  | meaning
// IDLE   | waiting for a descriptor; cfg_ready_o high
// ACTIVE | requesting words until bytes_left reaches zero
// DRAIN  | all words accepted; waiting for the final byte to leave
module idma_txrx_tx_endpoint
    import idma_txrx_tx_endpoint_pkg::*;
#(
    parameter int unsigned FifoDepth = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    cfg_valid_i,
    output logic                    cfg_ready_o,
    input  logic [TF_LEN_WIDTH-1:0] cfg_len_i,
    input  txrx_req_t               txrx_req_i,
    output txrx_rsp_t               txrx_rsp_o,
    output logic [7:0]              tx_byte_o,
    output logic                    tx_valid_o,
    input  logic                    tx_ready_i,
    output logic                    tx_last_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int unsigned PtrWidth  = $clog2(FifoDepth);
    localparam int unsigned FillWidth = PtrWidth + 1;

    endpoint_state_e r_state;
    tf_len_t         r_datasize;
    tf_len_t         r_bytes_left;
    logic            r_done;

    word_entry_t           r_fifo [FifoDepth];
    logic [PtrWidth-1:0]   r_wptr;
    logic [PtrWidth-1:0]   r_rptr;
    logic [FillWidth-1:0]  r_fill;

    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic        w_req;
    logic        w_ready;
    logic        w_push;
    logic        w_pop;
    byte_cnt_t   w_push_cnt;
    tf_len_t     w_left_next;
    word_entry_t w_entry;
    logic        w_final_hs;

    assign w_fifo_full  = (r_fill == FillWidth'(FifoDepth));
    assign w_fifo_empty = (r_fill == '0);
    assign w_req        = (r_state == ACTIVE) && (r_bytes_left != '0);
    // ready looks only at full, so a push is refused even when a pop frees a slot this cycle
    assign w_ready      = w_req && !w_fifo_full;
    assign w_push       = txrx_req_i.valid && w_ready;
    assign w_push_cnt   = push_bytes(r_bytes_left);
    assign w_left_next  = r_bytes_left - tf_len_t'(w_push_cnt);
    assign w_final_hs   = tx_valid_o && tx_ready_i && tx_last_o;

    assign w_entry.last = (w_left_next == '0);
    assign w_entry.cnt  = w_push_cnt;
    assign w_entry.data = txrx_req_i.a.data;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_datasize   <= '0;
            r_bytes_left <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cfg_valid_i) begin
                        r_datasize <= cfg_len_i;
                        if (cfg_len_i == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_bytes_left <= cfg_len_i;
                            r_state      <= ACTIVE;
                        end
                    end
                end
                ACTIVE: begin
                    if (w_push) begin
                        r_bytes_left <= w_left_next;
                        if (w_left_next == '0) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_final_hs) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fill <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PtrWidth'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PtrWidth'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + FillWidth'(1);
                2'b01:   r_fill <= r_fill - FillWidth'(1);
                default: r_fill <= r_fill;
            endcase
        end
    end

    // storage needs no reset: pointers and fill define what is valid
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo[r_wptr] <= w_entry;
        end
    end

    idma_txrx_tx_endpoint_serializer u_serializer (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .word_valid_i (!w_fifo_empty),
        .word_i       (r_fifo[r_rptr]),
        .word_pop_o   (w_pop),
        .tx_byte_o    (tx_byte_o),
        .tx_valid_o   (tx_valid_o),
        .tx_ready_i   (tx_ready_i),
        .tx_last_o    (tx_last_o)
    );

    assign cfg_ready_o = (r_state == IDLE);
    assign busy_o      = (r_state != IDLE);
    assign done_o      = r_done;

    assign txrx_rsp_o.r.datasize   = r_datasize;
    assign txrx_rsp_o.r.bytes_left = r_bytes_left;
    assign txrx_rsp_o.req          = w_req;
    assign txrx_rsp_o.ready        = w_ready;

endmodule

// File: tb/tb_idma_txrx_tx_endpoint.sv
// Bench for the TXRX write-port endpoint: random words and link backpressure,
// checked against a byte-stream model built from the offered words and length.
module tb_idma_txrx_tx_endpoint;
    import idma_txrx_tx_endpoint_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        cfg_valid_i = 1'b0;
    logic        cfg_ready_o;
    logic [31:0] cfg_len_i = '0;
    txrx_req_t   txrx_req_i = '0;
    txrx_rsp_t   txrx_rsp_o;
    logic [7:0]  tx_byte_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b0;
    logic        tx_last_o;
    logic        busy_o;
    logic        done_o;

    int n_cmp = 0;
    int n_err = 0;

    idma_txrx_tx_endpoint #(.FifoDepth(4)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cfg_valid_i (cfg_valid_i),
        .cfg_ready_o (cfg_ready_o),
        .cfg_len_i   (cfg_len_i),
        .txrx_req_i  (txrx_req_i),
        .txrx_rsp_o  (txrx_rsp_o),
        .tx_byte_o   (tx_byte_o),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready_i),
        .tx_last_o   (tx_last_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cfg_ready"},  64'(cfg_ready_o), 64'(1));
        chk({tag, "_busy"},       64'(busy_o), 64'(0));
        chk({tag, "_done"},       64'(done_o), 64'(0));
        chk({tag, "_tx_valid"},   64'(tx_valid_o), 64'(0));
        chk({tag, "_tx_byte"},    64'(tx_byte_o), 64'(0));
        chk({tag, "_tx_last"},    64'(tx_last_o), 64'(0));
        chk({tag, "_req"},        64'(txrx_rsp_o.req), 64'(0));
        chk({tag, "_ready"},      64'(txrx_rsp_o.ready), 64'(0));
        chk({tag, "_datasize"},   64'(txrx_rsp_o.r.datasize), 64'(0));
        chk({tag, "_bytes_left"}, 64'(txrx_rsp_o.r.bytes_left), 64'(0));
    endtask

    function automatic logic [31:0] mkword(input int k);
        return {8'((4*k+4)*17), 8'((4*k+3)*17), 8'((4*k+2)*17), 8'((4*k+1)*17)};
    endfunction

    // One transfer: directed picks 0x44332211-style words with valid held high,
    // hold keeps the link stalled for that many cycles, poke fires a stray cfg.
    task automatic run_xfer(input string tag, input int len, input bit directed,
                            input int rdy_pct, input int hold, input bit poke);
        logic [31:0] words[$];
        logic [31:0] cur;
        logic [7:0]  eb;
        bit          have_cur = 0;
        bit          finished = 0;
        int          pushes = 0;
        int          nbytes = 0;
        int          dones = 0;
        int          cyc = 0;
        int          exp_left;
        int          nwords = (len + 3) / 4;

        @(posedge clk_i); #1;
        cfg_valid_i = 1'b1;
        cfg_len_i   = 32'(len);
        @(negedge clk_i);
        chk({tag, "_cfg_ready"}, 64'(cfg_ready_o), 64'(1));
        @(posedge clk_i); #1;
        cfg_valid_i = 1'b0;
        @(negedge clk_i);
        if (len == 0) begin
            chk({tag, "_zero_done"}, 64'(done_o), 64'(1));
            chk({tag, "_zero_req"},  64'(txrx_rsp_o.req), 64'(0));
            chk({tag, "_zero_busy"}, 64'(busy_o), 64'(0));
            @(negedge clk_i);
            chk({tag, "_zero_done_pulse"}, 64'(done_o), 64'(0));
            chk({tag, "_zero_req2"},       64'(txrx_rsp_o.req), 64'(0));
            chk({tag, "_zero_idle"},       64'(cfg_ready_o), 64'(1));
            return;
        end
        chk({tag, "_busy"},       64'(busy_o), 64'(1));
        chk({tag, "_req"},        64'(txrx_rsp_o.req), 64'(1));
        chk({tag, "_datasize0"},  64'(txrx_rsp_o.r.datasize), 64'(len));
        chk({tag, "_bytes_left0"},64'(txrx_rsp_o.r.bytes_left), 64'(len));

        while (!finished && cyc < 400 + hold) begin
            @(posedge clk_i); #1;
            if (!have_cur) begin
                cur = directed ? mkword(pushes) : $urandom;
                have_cur = 1;
            end
            txrx_req_i.a.data = cur;
            txrx_req_i.valid  = directed ? 1'b1 : ($urandom_range(0, 99) < 80);
            tx_ready_i        = (cyc < hold) ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
            cfg_valid_i       = poke && (cyc == 3);
            if (poke && cyc == 3) cfg_len_i = 32'd77;
            @(negedge clk_i);
            if (cfg_valid_i) chk({tag, "_cfg_ignored"}, 64'(cfg_ready_o), 64'(0));
            if (txrx_req_i.valid && txrx_rsp_o.ready) begin
                exp_left = (len > 4 * pushes) ? len - 4 * pushes : 0;
                chk({tag, "_bytes_left"}, 64'(txrx_rsp_o.r.bytes_left), 64'(exp_left));
                chk({tag, "_datasize"},   64'(txrx_rsp_o.r.datasize), 64'(len));
                words.push_back(cur);
                pushes++;
                have_cur = 0;
            end
            if (hold > 0 && cyc >= hold && nbytes < len)
                chk({tag, "_no_gap"}, 64'(tx_valid_o), 64'(1));
            if (tx_valid_o && tx_ready_i) begin
                if (nbytes / 4 < words.size()) eb = 8'(words[nbytes / 4] >> (8 * (nbytes % 4)));
                else eb = 8'hxx;
                chk({tag, "_byte"}, 64'(tx_byte_o), 64'(eb));
                chk({tag, "_last"}, 64'(tx_last_o), 64'(nbytes == len - 1));
                nbytes++;
            end
            if (hold > 0 && cyc == hold - 1) begin
                chk({tag, "_stalled_words"}, 64'(pushes), 64'(5));
                chk({tag, "_stalled_ready"}, 64'(txrx_rsp_o.ready), 64'(0));
            end
            if (done_o) begin
                dones++;
                finished = 1;
            end
            cyc++;
        end
        cfg_valid_i      = 1'b0;
        txrx_req_i.valid = 1'b0;
        tx_ready_i       = 1'b0;
        chk({tag, "_finished"}, 64'(finished), 64'(1));
        chk({tag, "_words"},    64'(pushes), 64'(nwords));
        chk({tag, "_nbytes"},   64'(nbytes), 64'(len));
        chk({tag, "_dones"},    64'(dones), 64'(1));
        @(negedge clk_i);
        chk({tag, "_done_pulse"}, 64'(done_o), 64'(0));
        chk({tag, "_idle"},       64'(busy_o), 64'(0));
        chk({tag, "_cfg_ready2"}, 64'(cfg_ready_o), 64'(1));
        chk({tag, "_datasize_hold"}, 64'(txrx_rsp_o.r.datasize), 64'(len));
        chk({tag, "_left_end"},   64'(txrx_rsp_o.r.bytes_left), 64'(0));
    endtask

    initial begin
        int p;
        #1 rst_ni = 1'b0;
        #2 chk_reset_outputs("reset");
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        run_xfer("len8", 8, 1, 100, 0, 0);
        run_xfer("len6", 6, 1, 100, 0, 0);
        run_xfer("len0", 0, 0, 100, 0, 0);
        run_xfer("len64_stall", 64, 0, 100, 20, 0);
        run_xfer("cfg_poke", 12, 0, 70, 0, 1);
        for (int i = 0; i < 6; i++)
            run_xfer("rand", int'($urandom_range(1, 40)), 0, int'($urandom_range(30, 100)), 0, 0);

        // async reset while ACTIVE with two words accepted
        @(posedge clk_i); #1;
        cfg_valid_i = 1'b1;
        cfg_len_i   = 32'd16;
        @(posedge clk_i); #1;
        cfg_valid_i = 1'b0;
        tx_ready_i  = 1'b0;
        txrx_req_i.valid  = 1'b1;
        txrx_req_i.a.data = $urandom;
        p = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            if (txrx_req_i.valid && txrx_rsp_o.ready) p++;
            @(posedge clk_i); #1;
            if (p == 2) break;
            txrx_req_i.a.data = $urandom;
        end
        txrx_req_i.valid = 1'b0;
        chk("rst_mid_words", 64'(p), 64'(2));
        chk("rst_mid_busy",  64'(busy_o), 64'(1));
        #1 rst_ni = 1'b0;
        #1 chk_reset_outputs("rst_mid");
        @(negedge clk_i);
        chk("rst_mid_no_done", 64'(done_o), 64'(0));
        @(posedge clk_i); #1 rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_mid_no_done2", 64'(done_o), 64'(0));
        run_xfer("after_rst", 4, 0, 100, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
